// File: rtl/forward_net_batch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// forward_net_batch_sequencer_pkg
//   Shared types and defaults for the forward-net batch sequencer.
//   - data_type / double_data_type : signed fixed-point sample and cost types
//   - seq_state_t                  : sequencer FSM state encoding
//   - COUNT_DELAY_DEFAULT          : default net_load -> valid-output latency
// ---------------------------------------------------------------------------
package forward_net_batch_sequencer_pkg;

    localparam int DATA_W_DEFAULT      = 16;
    localparam int ACC_W_DEFAULT       = 32;
    localparam int COUNT_DELAY_DEFAULT = 4;

    typedef logic signed [DATA_W_DEFAULT-1:0] data_type;
    typedef logic signed [ACC_W_DEFAULT-1:0]  double_data_type;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/forward_net_batch_sequencer_cost_acc.sv
// ---------------------------------------------------------------------------
// fwd_seq_cost_acc
//   Sums the magnitudes of the L4 packed signed dAL lanes and adds the sum
//   into a saturating cost accumulator. Only built when the
//   FWD_SEQ_COST_ACCUM_EN macro is defined in the top.
// Ports
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero the accumulator (batch start)
//   add_en     : add |dAL| sum this cycle (result handshake)
//   dal        : L4*DATA_W packed signed output-layer error
//   cost_acc   : accumulated cost, saturates at 2^ACC_W-1
// ---------------------------------------------------------------------------
module fwd_seq_cost_acc #(
    parameter int L4     = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 add_en,
    input  logic [L4*DATA_W-1:0] dal,
    output logic [ACC_W-1:0]     cost_acc
);

    // Two guard bits beyond the lane count so the sum never overflows,
    // including the most-negative magnitude 2^(DATA_W-1).
    localparam int SUM_W  = DATA_W + $clog2(L4) + 2;
    localparam int WIDE_W = ACC_W + SUM_W;

    logic [SUM_W-1:0]  abs_sum;
    logic [DATA_W:0]   lane_ext;
    logic [DATA_W:0]   lane_mag;
    logic [WIDE_W-1:0] wide_sum;
    logic [ACC_W-1:0]  acc_q;

    always_comb begin
        abs_sum  = '0;
        lane_ext = '0;
        lane_mag = '0;
        for (int k = 0; k < L4; k++) begin
            // Sign-extend by one bit first so negating -2^(DATA_W-1) is exact.
            lane_ext = {dal[k*DATA_W + DATA_W - 1], dal[k*DATA_W +: DATA_W]};
            lane_mag = lane_ext[DATA_W] ? ((~lane_ext) + {{DATA_W{1'b0}}, 1'b1}) : lane_ext;
            abs_sum  = abs_sum + {{(SUM_W-DATA_W-1){1'b0}}, lane_mag};
        end
    end

    assign wide_sum = {{SUM_W{1'b0}}, acc_q} + {{ACC_W{1'b0}}, abs_sum};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (add_en) begin
            if (|wide_sum[WIDE_W-1:ACC_W]) begin
                acc_q <= '1;
            end else begin
                acc_q <= wide_sum[ACC_W-1:0];
            end
        end
    end

    assign cost_acc = acc_q;

endmodule

// File: rtl/forward_net_batch_sequencer.sv
// ---------------------------------------------------------------------------
// forward_net_batch_sequencer
//   Walks a batch of samples in sample memory in front of the forward net:
//   FETCH (request sample) -> LOAD (one-cycle net_load) -> WAIT (net_enable
//   for the network latency) -> CAPTURE (result handshake) -> next sample or
//   DONE. Batch status via done/aborted pulses.
//   Optional feature: macro FWD_SEQ_COST_ACCUM_EN enables the saturating
//   |dAL| cost accumulator (fwd_seq_cost_acc); otherwise cost_acc is 0.
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   start, abort        : batch start pulse (IDLE only), synchronous abort
//   base_addr,batch_len : latched on start
//   sample_req/ack      : sample fetch request / acknowledge
//   sample_addr         : current sample address (wraps mod 2^ADDR_W)
//   net_load,net_enable : forward-net load pulse and enable
//   dAL                 : packed output-layer error, valid in CAPTURE
//   result_valid/ready  : result handshake
//   sample_idx          : index of current sample in batch
//   busy, done, aborted : status
//   cost_acc            : accumulated batch cost
//   dbg_state           : current FSM state encoding
// Handshakes: a transfer happens on a rising edge where both the valid-side
//   signal (sample_req / result_valid) and the accepting signal (sample_ack /
//   result_ready) are high; the valid side holds steady until that edge.
//   abort in a busy state overrides any transfer in the same cycle.
// ---------------------------------------------------------------------------
module forward_net_batch_sequencer
    import forward_net_batch_sequencer_pkg::*;
#(
    parameter int L4          = 2,
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int ADDR_W      = 10,
    parameter int CNT_W       = 8,
    parameter int COUNT_DELAY = COUNT_DELAY_DEFAULT,
    parameter int ACC_W       = ACC_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     batch_len,
    output logic                 sample_req,
    input  logic                 sample_ack,
    output logic [ADDR_W-1:0]    sample_addr,
    output logic                 net_load,
    output logic                 net_enable,
    input  logic [L4*DATA_W-1:0] dAL,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CNT_W-1:0]     sample_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [ACC_W-1:0]     cost_acc,
    output logic [2:0]           dbg_state
);

    // Counter holds COUNT_DELAY-1 down to 0, so LOAD plus COUNT_DELAY WAIT
    // cycles precede CAPTURE.
    localparam int DLY_W = (COUNT_DELAY > 1) ? $clog2(COUNT_DELAY) : 1;
    localparam logic [DLY_W-1:0]  DLY_LOAD = DLY_W'(COUNT_DELAY - 1);
    localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    seq_state_t        state_q, state_d;
    logic [DLY_W-1:0]  dly_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  len_q;
    logic              aborted_q;
    logic              abort_hit;
    logic              last_sample;

    assign abort_hit   = abort && (state_q != S_IDLE);
    assign last_sample = (idx_q == (len_q - CNT_ONE));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state and Moore outputs ----------------
    always_comb begin
        state_d      = state_q;
        sample_req   = 1'b0;
        net_load     = 1'b0;
        net_enable   = 1'b0;
        result_valid = 1'b0;
        done         = 1'b0;
        busy         = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (batch_len != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                sample_req = 1'b1;
                if (sample_ack) state_d = S_LOAD;
            end
            S_LOAD: begin
                net_load   = 1'b1;
                net_enable = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                net_enable = 1'b1;
                if (dly_q == '0) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                result_valid = 1'b1;
                if (result_ready) state_d = last_sample ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_hit) state_d = S_IDLE;
    end

    // ---------------- delay, index and address counters ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_q     <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        len_q  <= batch_len;
                        idx_q  <= '0;
                    end
                end
                S_LOAD: dly_q <= DLY_LOAD;
                S_WAIT: begin
                    if (dly_q != '0) dly_q <= dly_q - DLY_ONE;
                end
                S_CAPTURE: begin
                    if (result_ready && !abort && !last_sample) begin
                        idx_q  <= idx_q + CNT_ONE;
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_addr = addr_q;
    assign sample_idx  = idx_q;
    assign aborted     = aborted_q;
    assign dbg_state   = state_q;

    // ---------------- optional cost accumulator ----------------
`ifdef FWD_SEQ_COST_ACCUM_EN
    logic cost_clear;
    logic cost_add;

    assign cost_clear = (state_q == S_IDLE) && start && (batch_len != '0);
    assign cost_add   = (state_q == S_CAPTURE) && result_ready && !abort;

    fwd_seq_cost_acc #(
        .L4     (L4),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_cost_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (cost_clear),
        .add_en   (cost_add),
        .dal      (dAL),
        .cost_acc (cost_acc)
    );
`else
    logic unused_dal;
    assign unused_dal = ^dAL;
    assign cost_acc   = '0;
`endif

endmodule

// File: tb/tb_forward_net_batch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_forward_net_batch_sequencer
//   Drives batches with random fetch/result delays and random dAL data and
//   compares against a transaction-level model: an expected address queue,
//   fixed latency from the network delay, done/aborted pulse expectations and
//   an arithmetic |dAL| cost sum clamped at the accumulator maximum.
// ---------------------------------------------------------------------------
module tb_forward_net_batch_sequencer;

    localparam int L4          = 2;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 10;
    localparam int CNT_W       = 8;
    localparam int COUNT_DELAY = 4;
`ifdef FWD_SEQ_COST_ACCUM_EN
    localparam int ACC_W = 18;
`else
    localparam int ACC_W = 32;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [ADDR_W-1:0]    base_addr = '0;
    logic [CNT_W-1:0]     batch_len = '0;
    logic                 sample_req;
    logic                 sample_ack = 1'b0;
    logic [ADDR_W-1:0]    sample_addr;
    logic                 net_load;
    logic                 net_enable;
    logic [L4*DATA_W-1:0] dAL = '0;
    logic                 result_valid;
    logic                 result_ready = 1'b0;
    logic [CNT_W-1:0]     sample_idx;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [ACC_W-1:0]     cost_acc;
    logic [2:0]           dbg_state;

    forward_net_batch_sequencer #(
        .L4          (L4),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W),
        .COUNT_DELAY (COUNT_DELAY),
        .ACC_W       (ACC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .batch_len    (batch_len),
        .sample_req   (sample_req),
        .sample_ack   (sample_ack),
        .sample_addr  (sample_addr),
        .net_load     (net_load),
        .net_enable   (net_enable),
        .dAL          (dAL),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sample_idx   (sample_idx),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .cost_acc     (cost_acc),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W-1:0] exp_q[$];
    longint model_cost = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint exp_cost();
        longint sat;
`ifdef FWD_SEQ_COST_ACCUM_EN
        sat = (longint'(1) << ACC_W) - 1;
        return (model_cost > sat) ? sat : model_cost;
`else
        sat = 0;
        return sat;
`endif
    endfunction

    function automatic longint abs16(input logic signed [DATA_W-1:0] v);
        longint x;
        x = longint'(v);
        return (x < 0) ? -x : x;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req"}, sample_req, 0);
        check({tag, "_en"}, net_enable, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // ---------------- driver: one full batch ----------------
    // dal_mode: 0 random, 1 {-3,5}, 2 both lanes most-negative.
    // abort_sample >= 0 aborts in WAIT of that sample.
    task automatic run_batch(input logic [ADDR_W-1:0] base, input int len,
                             input int ack_dly, input int rdy_dly, input bit fixed_dly,
                             input int abort_sample, input bit start_abort, input int dal_mode);
        int d, lat, en_cnt;
        logic signed [DATA_W-1:0] a, b;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(base + ADDR_W'(i));
        model_cost = 0;

        start = 1'b1; base_addr = base; batch_len = CNT_W'(len); abort = start_abort;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        base_addr = ADDR_W'($urandom); batch_len = CNT_W'($urandom);
        check("busy_after_start", busy, 1);
        check("no_abort_in_idle", aborted, 0);

        for (int i = 0; i < len; i++) begin
            check("fetch_req", sample_req, 1);
            check("fetch_idx", sample_idx, CNT_W'(i));
            d = fixed_dly ? ack_dly : $urandom_range(0, ack_dly);
            for (int j = 0; j < d; j++) begin
                sample_ack = 1'b0;
                @(negedge clk);
                check("req_held", sample_req, 1);
                check("no_load_in_fetch", net_load, 0);
                check("idx_held_fetch", sample_idx, CNT_W'(i));
            end
            sample_ack = 1'b1;
            @(negedge clk);
            sample_ack = 1'($urandom_range(0, 1));
            check("net_load", net_load, 1);
            check("load_enable", net_enable, 1);
            check("load_addr", sample_addr, exp_q.pop_front());

            lat = 0; en_cnt = 1;
            while (!result_valid && lat < 40) begin
                if (i == abort_sample && lat == 2) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("aborted_pulse", aborted, 1);
                    check("abort_busy", busy, 0);
                    check("abort_no_done", done, 0);
                    @(negedge clk);
                    check("aborted_once", aborted, 0);
                    check("abort_no_done2", done, 0);
                    check("abort_cost_kept", cost_acc, exp_cost());
                    exp_q.delete();
                    sample_ack = 1'b0;
                    return;
                end
                @(negedge clk);
                lat++;
                if (net_enable) en_cnt++;
                if (!result_valid) check("no_reload_wait", net_load, 0);
            end
            check("latency", lat, COUNT_DELAY + 1);
            check("enable_cycles", en_cnt, COUNT_DELAY + 1);
            check("valid_enable_low", net_enable, 0);

            d = fixed_dly ? rdy_dly : $urandom_range(0, rdy_dly);
            for (int j = 0; j < d; j++) begin
                result_ready = 1'b0;
                start = (j == 0);
                @(negedge clk);
                start = 1'b0;
                check("valid_held", result_valid, 1);
                check("idx_held_capture", sample_idx, CNT_W'(i));
                check("no_load_capture", net_load, 0);
            end

            case (dal_mode)
                1: begin a = -16'sd3; b = 16'sd5; end
                2: begin a = 16'sh8000; b = 16'sh8000; end
                default: begin a = DATA_W'($urandom); b = DATA_W'($urandom); end
            endcase
            dAL = {b, a};
            model_cost += abs16(a) + abs16(b);
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            dAL = L4*DATA_W'($urandom);
        end

        check("done_pulse", done, 1);
        check("done_no_req", sample_req, 0);
        @(negedge clk);
        check("done_once", done, 0);
        check("busy_fall", busy, 0);
        check("batch_cost", cost_acc, exp_cost());
        sample_ack = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_addr", sample_addr, 0);
        check("reset_idx", sample_idx, 0);
        check("reset_cost", cost_acc, 0);
        check("reset_aborted", aborted, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single batch with address wrap, immediate ack/ready.
        run_batch(10'h3FE, 3, 0, 0, 1'b1, -1, 1'b0, 0);

        // Backpressure: ack 3 cycles late, ready low 4 cycles.
        run_batch(ADDR_W'($urandom), 3, 3, 4, 1'b1, -1, 1'b0, 0);

        // Abort in WAIT of sample 1 of 4, then a full restart.
        run_batch(10'h100, 4, 1, 1, 1'b0, 1, 1'b0, 0);
        run_batch(10'h100, 4, 1, 1, 1'b0, -1, 1'b0, 0);

        // start and abort together in IDLE: start wins.
        run_batch(ADDR_W'($urandom), 2, 2, 2, 1'b0, -1, 1'b1, 0);

        // Zero-length batch.
        start = 1'b1; batch_len = '0; base_addr = ADDR_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_no_req", sample_req, 0);
        @(negedge clk);
        check("len0_done_once", done, 0);
        check("len0_idle", busy, 0);
        check("len0_no_req2", sample_req, 0);

        // Cost: {-3,5} over two samples, then saturation.
        run_batch(ADDR_W'($urandom), 2, 0, 0, 1'b1, -1, 1'b0, 1);
        run_batch(ADDR_W'($urandom), 5, 1, 1, 1'b0, -1, 1'b0, 2);

        // Random batches.
        for (int n = 0; n < 6; n++) begin
            run_batch(ADDR_W'($urandom), $urandom_range(1, 6), 3, 4, 1'b0, -1, 1'b0, 0);
        end

        // Reset low mid-WAIT.
        start = 1'b1; batch_len = CNT_W'(2); base_addr = 10'h055; sample_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_enable", net_enable, 1);
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        check("midreset_addr", sample_addr, 0);
        check("midreset_idx", sample_idx, 0);
        check("midreset_cost", cost_acc, 0);
        sample_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
